johnson_phase_decoder: RTL and testbench

Registered consumer stage placed directly downstream of `johnson_counter`. It samples the counter's `count` bus and decodes each legal Johnson pattern into a phase index and a one-hot phase vector. It checks that successive samples advance by exactly one step, modulo 2N. It runs a lock state machine and a saturating error counter so that corrupted or skipped counter states are flagged and never forwarded as valid phases.

---
 rtl/johnson_pkg.sv | 19 +
 rtl/johnson_index.sv | 39 +++
 rtl/johnson_phase_decoder.sv | 115 +++++++++++
 tb/tb_johnson_phase_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared definitions for consumers of the Johnson counter: FSM state
// encodings and the phase-index width helper.
package johnson_pkg;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef enum logic [1:0] {
    SEARCH = ST_SEARCH,
    TRACK  = ST_TRACK,
    LOCKED = ST_LOCKED
  } state_t;

  function automatic int calc_iw(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/johnson_index.sv
// Combinational decode of a Johnson counter value into a legality flag and
// a phase index in 0..2N-1.
module johnson_index
  import johnson_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = calc_iw(N)
) (
  input  logic [N-1:0]  count,
  output logic          legal,
  output logic [IW-1:0] idx
);

  int ones;
  logic [N-1:0] lo_pat;
  logic [N-1:0] hi_pat;

  // A legal pattern is a run of ones anchored at the LSB (MSB clear) or at the MSB (MSB set).
  always_comb begin
    ones   = 0;
    lo_pat = '0;
    hi_pat = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + int'(count[i]);
    end
    for (int i = 0; i < N; i++) begin
      lo_pat[i] = (i < ones);
      hi_pat[i] = (i >= N - ones);
    end
    if (count[N-1]) begin
      legal = (count == hi_pat);
      idx   = IW'(2 * N - ones);
    end else begin
      legal = (count == lo_pat);
      idx   = IW'(ones);
    end
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Registered phase decoder for a Johnson counter: checks single-step advance,
// locks after a run of good steps and counts errors seen while locked.
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8,
  localparam int IW = calc_iw(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     count,
  output logic             legal,
  output logic [IW-1:0]    idx,
  output logic [2*N-1:0]   phase,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GW   = (LOCK_LEN > 1) ? $clog2(LOCK_LEN) : 1;
  localparam int PW   = 2 * N;
  localparam int LAST = 2 * N - 1;

  state_t          state;
  logic [IW-1:0]   prev_idx;
  logic [GW-1:0]   good;
  logic            s_legal;
  logic [IW-1:0]   s_idx;
  logic [IW-1:0]   next_idx;
  logic            step;
  logic [PW-1:0]   one_hot;

  johnson_index #(.N(N)) u_index (
    .count (count),
    .legal (s_legal),
    .idx   (s_idx)
  );

  assign next_idx = (prev_idx == IW'(LAST)) ? '0 : prev_idx + 1'b1;
  assign step     = s_legal && (s_idx == next_idx);
  assign one_hot  = PW'(1) << s_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SEARCH;
      prev_idx <= '0;
      good     <= '0;
      legal    <= 1'b0;
      idx      <= '0;
      phase    <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      err <= 1'b0;
      if (en) begin
        legal <= s_legal;
        if (s_legal) begin
          idx      <= s_idx;
          prev_idx <= s_idx;
        end
        case (state)
          SEARCH: begin
            if (s_legal) begin
              state <= TRACK;
              good  <= '0;
            end
          end
          TRACK: begin
            if (!s_legal) begin
              state <= SEARCH;
              good  <= '0;
            end else if (step) begin
              if (good == GW'(LOCK_LEN - 1)) begin
                state  <= LOCKED;
                good   <= '0;
                locked <= 1'b1;
                phase  <= one_hot;
              end else begin
                good <= good + 1'b1;
              end
            end else begin
              good <= '0;
            end
          end
          LOCKED: begin
            if (step) begin
              phase <= one_hot;
            end else begin
              // Any break while locked drops the lock and is the only place errors are counted.
              state  <= s_legal ? TRACK : SEARCH;
              good   <= '0;
              locked <= 1'b0;
              phase  <= '0;
              err    <= 1'b1;
              if (err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
              end
            end
          end
          default: begin
            state  <= SEARCH;
            good   <= '0;
            locked <= 1'b0;
            phase  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed self-checking bench for johnson_phase_decoder with a run-length
// lock model built from the generated Johnson sequence.
module tb_johnson_phase_decoder;

  localparam int N        = 4;
  localparam int LOCK_LEN = 4;
  localparam int ERR_W    = 8;
  localparam int IW       = 3;
  localparam int SEQ      = 2 * N;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [N-1:0]     count;
  logic             legal;
  logic [IW-1:0]    idx;
  logic [SEQ-1:0]   phase;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  logic [N-1:0] pat [SEQ];
  bit  m_acq;
  int  m_prev;
  int  m_run;
  bit  m_legal;
  int  m_idx;
  bit  m_locked;
  bit  m_err;
  int  m_err_cnt;

  int  checks = 0;
  int  errors = 0;
  bit  cmp_on = 1'b0;
  int  cur;

  johnson_phase_decoder #(.N(N), .LOCK_LEN(LOCK_LEN), .ERR_W(ERR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .count   (count),
    .legal   (legal),
    .idx     (idx),
    .phase   (phase),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int lookup(input logic [N-1:0] c);
    for (int i = 0; i < SEQ; i++) begin
      if (pat[i] == c) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_acq = 0; m_prev = 0; m_run = 0; m_legal = 0;
    m_idx = 0; m_locked = 0; m_err = 0; m_err_cnt = 0;
  endtask

  // Lock means the last LOCK_LEN samples were all one-step advances after an acquisition.
  task automatic model_step(input logic e, input logic [N-1:0] c);
    int li;
    bit stepped;
    m_err = 0;
    if (!rst || !e) return;
    li = lookup(c);
    stepped = (li >= 0) && m_acq && (li == (m_prev + 1) % SEQ);
    m_err = m_locked && !stepped;
    m_legal = (li >= 0);
    if (li >= 0) begin
      m_run  = stepped ? m_run + 1 : 0;
      m_acq  = 1;
      m_prev = li;
      m_idx  = li;
    end else begin
      m_acq = 0;
      m_run = 0;
    end
    m_locked = (m_run >= LOCK_LEN);
    if (m_err && m_err_cnt < (1 << ERR_W) - 1) m_err_cnt++;
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check_output("legal", int'(legal), int'(m_legal));
      check_output("idx", int'(idx), m_idx);
      check_output("phase", int'(phase), m_locked ? (1 << m_idx) : 0);
      check_output("locked", int'(locked), int'(m_locked));
      check_output("err", int'(err), int'(m_err));
      check_output("err_cnt", int'(err_cnt), m_err_cnt);
    end
  end

  task automatic apply_stimulus(input logic e, input logic [N-1:0] c);
    en = e;
    count = c;
    @(posedge clk);
    #1;
    model_step(e, c);
    @(negedge clk);
    #1;
  endtask

  task automatic step_next();
    cur = (cur + 1) % SEQ;
    apply_stimulus(1'b1, pat[cur]);
  endtask

  initial begin
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < SEQ; i++) begin
      pat[i] = p;
      p = {p[N-2:0], ~p[N-1]};
    end
    model_reset();
    rst = 1'b0;
    en = 1'b0;
    count = '0;
    cmp_on = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check_output("rst_locked", int'(locked), 0);
    check_output("rst_phase", int'(phase), 0);
    check_output("rst_err_cnt", int'(err_cnt), 0);
    en = 1'b1;
    count = 4'b0011;
    @(negedge clk);
    #1;
    check_output("rst_hold_legal", int'(legal), 0);
    check_output("rst_hold_idx", int'(idx), 0);
    rst = 1'b1;

    cur = 0;
    apply_stimulus(1'b1, pat[0]);
    for (int k = 0; k < LOCK_LEN; k++) begin
      step_next();
      if (k == LOCK_LEN - 2) check_output("lock_not_early", int'(locked), 0);
    end
    check_output("lock_rise", int'(locked), 1);
    check_output("lock_idx", int'(idx), 4);
    check_output("lock_phase", int'(phase), 'h10);
    check_output("lock_err_cnt", int'(err_cnt), 0);

    for (int k = 0; k < 4; k++) begin
      step_next();
      if (cur == 7) check_output("phase_7", int'(phase), 'h80);
    end
    check_output("phase_wrap", int'(phase), 'h01);
    check_output("locked_wrap", int'(locked), 1);

    apply_stimulus(1'b1, 4'b0101);
    check_output("bad_legal", int'(legal), 0);
    check_output("bad_idx_hold", int'(idx), 0);
    check_output("bad_locked", int'(locked), 0);
    check_output("bad_phase", int'(phase), 0);
    check_output("bad_err", int'(err), 1);
    check_output("bad_err_cnt", int'(err_cnt), 1);
    for (int k = 0; k < 5; k++) begin
      step_next();
      if (k == 3) check_output("relock_not_early", int'(locked), 0);
    end
    check_output("relock", int'(locked), 1);

    while (cur != 2) step_next();
    cur = 4;
    apply_stimulus(1'b1, pat[cur]);
    check_output("skip_err", int'(err), 1);
    check_output("skip_locked", int'(locked), 0);
    check_output("skip_idx", int'(idx), 4);
    check_output("skip_err_cnt", int'(err_cnt), 2);
    for (int k = 0; k < 4; k++) begin
      step_next();
      if (k == 2) check_output("track_not_early", int'(locked), 0);
    end
    check_output("track_relock", int'(locked), 1);

    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b0, pat[(cur + 3 + k) % SEQ]);
      check_output("hold_idx", int'(idx), 0);
      check_output("hold_phase", int'(phase), 'h01);
    end
    step_next();
    check_output("after_hold_phase", int'(phase), 'h02);
    check_output("after_hold_err_cnt", int'(err_cnt), 2);

    for (int k = 0; k < 260; k++) begin
      cur = (cur + 3) % SEQ;
      apply_stimulus(1'b1, pat[cur]);
      repeat (LOCK_LEN) step_next();
    end
    check_output("sat_err_cnt", int'(err_cnt), 'hFF);
    check_output("sat_locked", int'(locked), 1);

    en = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_output("async_locked", int'(locked), 0);
    check_output("async_phase", int'(phase), 0);
    check_output("async_err_cnt", int'(err_cnt), 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    cur = 0;
    apply_stimulus(1'b1, pat[0]);
    repeat (LOCK_LEN) step_next();
    check_output("post_rst_lock", int'(locked), 1);
    check_output("post_rst_idx", int'(idx), 4);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
